// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation codes, FSM states and the flag bundle.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_MUL = 3'b110,
    ALU_SLL = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } alu_state_t;

  // Field order matches the {N,Z,C,V} flags port.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial-product step per cycle, WIDTH steps per op.
module alu_mul_iter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [WIDTH:0]   partial;
  logic             last;

  // lo_q starts as the multiplier and is consumed LSB-first as product bits shift in.
  assign partial = lo_q[0] ? ({1'b0, hi_q} + {1'b0, mcand_q}) : {1'b0, hi_q};
  assign last    = busy_q && (cnt_q == CNT_W'(WIDTH - 1));

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (start) begin
      mcand_q <= a;
      hi_q    <= '0;
      lo_q    <= b;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      {hi_q, lo_q} <= {partial, lo_q[WIDTH-1:1]};
      cnt_q        <= cnt_q + CNT_W'(1);
      if (last) busy_q <= 1'b0;
    end
  end

  assign busy    = busy_q;
  assign done    = last;
  assign prod_hi = hi_q;
  assign prod_lo = lo_q;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, N/Z/C/V flags and a WIDTH-cycle multiplier.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] ALUResultHi,
  output logic [3:0]       flags
);

  localparam int SH_W = $clog2(WIDTH);

  alu_state_t       state_q, state_d;
  alu_op_t          op;
  logic             accept;
  logic             mul_start, mul_busy, mul_done;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic [WIDTH-1:0] res_d, res_q;
  logic [WIDTH:0]   sum;
  alu_flags_t       flg_d, flg_q, mul_flg;
  logic             is_mul_q;

  assign op        = alu_op_t'(ALUControl);
  assign in_ready  = (state_q == S_IDLE) && !mul_busy;
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == ALU_MUL);

  alu_mul_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .prod_hi (mul_hi),
    .prod_lo (mul_lo)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    sum   = '0;
    res_d = '0;
    flg_d = '0;
    unique case (op)
      ALU_ADD: sum = {1'b0, a} + {1'b0, b};
      ALU_SUB: sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
      ALU_AND: res_d = a & b;
      ALU_OR:  res_d = a | b;
      ALU_XOR: res_d = a ^ b;
      ALU_SLT: res_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLL: res_d = a << b[SH_W-1:0];
      default: res_d = '0;
    endcase
    if (op == ALU_ADD || op == ALU_SUB) begin
      res_d   = sum[WIDTH-1:0];
      flg_d.c = sum[WIDTH];
      // Overflow when the effective operand signs agree but the result sign differs.
      flg_d.v = (op == ALU_ADD)
              ? ((a[WIDTH-1] == b[WIDTH-1]) && (res_d[WIDTH-1] != a[WIDTH-1]))
              : ((a[WIDTH-1] != b[WIDTH-1]) && (res_d[WIDTH-1] != a[WIDTH-1]));
    end
    flg_d.n = res_d[WIDTH-1];
    flg_d.z = (res_d == '0);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept)    state_d = (op == ALU_MUL) ? S_MUL : S_DONE;
      S_MUL:   if (mul_done)  state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // NOTE: result registers are reset along with the FSM so an aborted op never leaks out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      res_q    <= '0;
      flg_q    <= '0;
      is_mul_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_mul_q <= (op == ALU_MUL);
        res_q    <= res_d;
        flg_q    <= flg_d;
      end
    end
  end

  // The multiplier holds its product after finishing, so MUL results are read from it directly.
  always_comb begin
    mul_flg   = '0;
    mul_flg.n = mul_lo[WIDTH-1];
    mul_flg.z = (mul_lo == '0);
    mul_flg.c = |mul_hi;
  end

  assign ALUResult   = is_mul_q ? mul_lo : res_q;
  assign ALUResultHi = is_mul_q ? mul_hi : '0;
  assign flags       = is_mul_q ? mul_flg : flg_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases plus random ops against an arithmetic model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [2:0] ctl = '0;
  logic       in_ready, out_valid;
  logic [7:0] res, res_hi;
  logic [3:0] flags;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .ALUControl  (ctl),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ALUResult   (res),
    .ALUResultHi (res_hi),
    .flags       (flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic on the op definitions, then truncation to WIDTH bits.
  function automatic void model(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                                output logic [7:0] lo, output logic [7:0] hi,
                                output logic [3:0] f);
    int ux, uy, sx, sy, r, sr;
    logic c, v;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    r = 0; c = 1'b0; v = 1'b0; hi = '0;
    case (op)
      3'd0: begin r = ux + uy; c = (r > 255); sr = sx + sy; v = (sr > 127) || (sr < -128); end
      3'd1: begin r = ux - uy; c = (ux >= uy); sr = sx - sy; v = (sr > 127) || (sr < -128); end
      3'd2: r = ux & uy;
      3'd3: r = ux | uy;
      3'd4: r = ux ^ uy;
      3'd5: r = (sx < sy) ? 1 : 0;
      3'd6: begin r = ux * uy; hi = 8'((r / 256) % 256); c = (hi != 0); end
      default: r = ux << (uy % WIDTH);
    endcase
    lo = 8'(r & 255);
    f = '0;
    f[FLAG_N] = lo[7];
    f[FLAG_Z] = (lo == 0);
    f[FLAG_C] = c;
    f[FLAG_V] = v;
  endfunction

  task automatic scramble();
    in_valid = 1'($urandom_range(0, 1));
    a        = 8'($urandom);
    b        = 8'($urandom);
    ctl      = 3'($urandom_range(0, 7));
  endtask

  task automatic run_op(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                        input int stall);
    logic [7:0] e_lo, e_hi;
    logic [3:0] e_f;
    int n, n_exp, busy_cyc;
    string nm;
    model(op, x, y, e_lo, e_hi, e_f);
    nm = $sformatf("op%0d_%0h_%0h", op, x, y);
    n_exp = (op == 3'd6) ? WIDTH : 0;
    @(negedge clk);
    check({nm, ":ready_before"}, in_ready, 1);
    in_valid = 1'b1; a = x; b = y; ctl = op;
    @(posedge clk);
    #1 scramble();
    n = 0;
    busy_cyc = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      if (!in_ready) busy_cyc++;
      scramble();
      n++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check({nm, ":latency"}, n, n_exp);
    for (int s = 0; s <= stall; s++) begin
      if (s > 0) begin
        scramble();
        @(negedge clk);
        in_valid = 1'b0;
      end
      if (!in_ready) busy_cyc++;
      check({nm, ":out_valid"}, out_valid, 1);
      check({nm, ":in_ready_busy"}, in_ready, 0);
      check({nm, ":result"}, res, e_lo);
      check({nm, ":result_hi"}, res_hi, e_hi);
      check({nm, ":flags"}, flags, e_f);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({nm, ":busy_cycles"}, busy_cyc, n_exp + 1 + stall);
    check({nm, ":out_valid_after"}, out_valid, 0);
    check({nm, ":ready_after"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("reset:in_ready", in_ready, 1);
    check("reset:out_valid", out_valid, 0);
    check("reset:result", res, 0);
    check("reset:result_hi", res_hi, 0);
    check("reset:flags", flags, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd0, 8'd23, 8'd23, 0);
    run_op(3'd1, 8'd23, 8'd23, 0);
    run_op(3'd0, 8'd100, 8'd100, 0);
    run_op(3'd0, 8'd200, 8'd100, 0);
    run_op(3'd5, 8'hFF, 8'h01, 0);
    run_op(3'd6, 8'd23, 8'd23, 0);
    run_op(3'd0, 8'd5, 8'd3, 3);
    run_op(3'd6, 8'd0, 8'd77, 1);
    run_op(3'd6, 8'hFF, 8'hFF, 0);
    run_op(3'd7, 8'h81, 8'd9, 0);
    run_op(3'd1, 8'd0, 8'd1, 0);
    run_op(3'd1, 8'h80, 8'h01, 0);

    // Abort a multiply after four steps; reset must clear outputs without a clock edge.
    @(negedge clk);
    in_valid = 1'b1; a = 8'd23; b = 8'd23; ctl = 3'd6;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort:in_ready", in_ready, 1);
    check("abort:out_valid", out_valid, 0);
    check("abort:result", res, 0);
    check("abort:result_hi", res_hi, 0);
    check("abort:flags", flags, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_abort:in_ready", in_ready, 1);
    check("post_abort:out_valid", out_valid, 0);
    run_op(3'd0, 8'd1, 8'd1, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 8-bit combinational ALU.
- Width is generic and the op set widens to 3 bits.
- Adds N/Z/C/V flags and an iterative shift-add multiplier that takes WIDTH cycles.
- Sits between the register-file read stage and writeback, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- CNT_W, $clog2(WIDTH+1), width of the multiply step counter (derived; do not override).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and op present.
- in_ready  output  1  block can accept an op.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ALUControl  input  3  operation select (alu_op_t).
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer takes the result.
- ALUResult  output  WIDTH  result (low half for MUL).
- ALUResultHi  output  WIDTH  high half of the MUL product; 0 for all other ops.
- flags  output  4  {N,Z,C,V}.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, ALUResult=0, ALUResultHi=0, flags=0, counter=0.
- State machine, states IDLE, MUL, DONE:
  - in_ready=1 only in IDLE.
  - Accept occurs when in_valid & in_ready at a rising edge; a, b and ALUControl are captured at that edge.
- Single-cycle ops go IDLE->DONE at the accept edge. out_valid is high in the next cycle.
- MUL goes IDLE->MUL at accept, with counter=0.
  - Each MUL edge performs one shift-add step and increments the counter.
  - After WIDTH steps the block enters DONE. out_valid rises WIDTH edges after the accept edge.
- DONE: outputs and flags are held stable while out_ready=0. DONE->IDLE on out_valid & out_ready; out_valid drops in the same edge.
- Peak throughput is one op per 2 cycles.
- Ops and results:
  - 000 ADD: a+b.
  - 001 SUB: a-b, computed as a+~b+1.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLT: signed a<b gives 1, else 0.
  - 110 MUL: unsigned a*b. {ALUResultHi,ALUResult} = 2*WIDTH-bit product.
  - 111 SLL: a << b[$clog2(WIDTH)-1:0].
- Flags:
  - N = ALUResult[WIDTH-1].
  - Z = (ALUResult==0).
  - C: ADD gives the carry out. SUB gives the carry out of a+~b+1, so 1 means no borrow. MUL gives (ALUResultHi!=0). All other ops give 0.
  - V: ADD/SUB give two's-complement signed overflow. All other ops give 0.
- ALUResultHi is 0 for every op except MUL.
- Boundary cases:
  - in_valid while not IDLE is ignored; the source must hold it.
  - Inputs changing during MUL have no effect on the result.
  - rst_n asserted mid-MUL or in DONE aborts the op. The result is discarded and the block returns to the reset values.
  - MUL by 0 still takes WIDTH cycles.
  - SLL shift by >= WIDTH cannot occur because the shift amount is masked to $clog2(WIDTH) bits.

Decomposition:
- Package alu_pkg contains:
  - alu_op_t, a 3-bit enum: ADD, SUB, AND, OR, XOR, SLT, MUL, SLL.
  - alu_state_t enum: IDLE, MUL, DONE.
  - alu_flags_t packed struct {N,Z,C,V}.
  - Constants FLAG_N/Z/C/V bit indices.
- Sub-module alu_mul_iter (WIDTH): start/busy/done interface with a WIDTH-cycle shift-add datapath, instantiated once.
- Single-cycle ops are an always_comb inside alu_seq.

Test Plan:
- WIDTH=8, a=23, b=23, ADD then SUB.
  - ADD: out_valid one cycle after accept, ALUResult=46, flags=0000.
  - SUB: ALUResult=0, Z=1, C=1, N=0, V=0.
- Overflow and carry cases:
  - ADD a=100, b=100 gives 200, N=1, V=1, C=0.
  - ADD a=200, b=100 gives 44, C=1, V=0.
- SLT a=8'hFF, b=8'h01 gives ALUResult=1.
- MUL a=23, b=23:
  - in_ready low for 9 cycles.
  - out_valid exactly 8 edges after the accept edge.
  - ALUResult=8'h11, ALUResultHi=8'h02, C=1.
- Back-pressure: ADD 5+3 with out_ready held low 3 cycles.
  - ALUResult=8 stable and out_valid high throughout; in_ready=0.
  - After the handshake edge: out_valid=0, in_ready=1.
- Reset mid-MUL: assert rst_n=0 at step 4 of MUL 23*23.
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - After release: in_ready=1, out_valid=0.
  - A following ADD 1+1 returns 2.
